// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder and other serial datapath blocks.
package bit_serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bits needed to count 0..n-1 (ceil(log2(n))).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (((n - 1) >> i) != 0) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_valid;
  logic             i_ready;
  logic             o_busy;

  modport master (
    output i_a, i_b, i_valid, i_ready,
    input  o_ready, o_sum, o_carry, o_valid, o_busy
  );

  modport slave (
    input  i_a, i_b, i_valid, i_ready,
    output o_ready, o_sum, o_carry, o_valid, o_busy
  );
endinterface

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full-add cell: two half-add stages with the carries OR-ed.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic hs1;
  logic hc1;
  logic hc2;

  assign hs1 = a ^ b;
  assign hc1 = a & b;
  assign s   = hs1 ^ cin;
  assign hc2 = hs1 & cin;
  assign co  = hc1 | hc2;
endmodule

// File: rtl/bit_serial_adder.sv
// Streams two operands LSB-first through one full-add cell with a registered
// carry and returns the parallel sum plus carry-out over valid/ready.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bit_serial_adder_if.slave  bus
);
  localparam int unsigned CW = clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic [WIDTH-1:0] sum_sr, sum_sr_nxt;
  logic [WIDTH-1:0] sum_q, sum_nxt;
  logic             carry, carry_nxt;
  logic             cout_q, cout_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ready_q, valid_q, busy_q;
  logic             fa_s, fa_co;

  serial_fa_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state;
    a_sr_nxt   = a_sr;
    b_sr_nxt   = b_sr;
    sum_sr_nxt = sum_sr;
    sum_nxt    = sum_q;
    carry_nxt  = carry;
    cout_nxt   = cout_q;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          a_sr_nxt  = bus.i_a;
          b_sr_nxt  = bus.i_b;
          carry_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        sum_sr_nxt = {fa_s, sum_sr[WIDTH-1:1]};
        carry_nxt  = fa_co;
        a_sr_nxt   = a_sr >> 1;
        b_sr_nxt   = b_sr >> 1;
        cnt_nxt    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          sum_nxt   = sum_sr_nxt;
          cout_nxt  = fa_co;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_sr    <= a_sr_nxt;
      b_sr    <= b_sr_nxt;
      sum_sr  <= sum_sr_nxt;
      sum_q   <= sum_nxt;
      carry   <= carry_nxt;
      cout_q  <= cout_nxt;
      cnt     <= cnt_nxt;
      // Status flags are registered copies of the state they decode.
      ready_q <= (state_nxt == IDLE);
      valid_q <= (state_nxt == DONE);
      busy_q  <= (state_nxt == RUN);
    end
  end

  assign bus.o_sum   = sum_q;
  assign bus.o_carry = cout_q;
  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed vector table, corner
// sequences and a random back-to-back stream against an arithmetic model.
module tb_bit_serial_adder;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
    int         hold;
    bit         disturb;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete transaction; hold = cycles of i_ready=0 after o_valid.
  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_s, input logic exp_c,
                       input int hold, input bit disturb);
    int w;
    int lat;
    w = 0;
    while (!bus.o_ready && w < 50) begin tick(); w++; end
    chk({nm, "_ready_idle"}, 32'(bus.o_ready), 32'd1);
    bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1;
    bus.i_ready = (hold == 0);
    tick();
    bus.i_valid = 1'b0;
    chk({nm, "_busy"}, 32'(bus.o_busy), 32'd1);
    lat = 0;
    while (!bus.o_valid && lat < 50) begin
      if (disturb) begin
        chk({nm, "_ready_run"}, 32'(bus.o_ready), 32'd0);
        bus.i_a = 8'($urandom);
        bus.i_b = 8'($urandom);
        bus.i_valid = ~bus.i_valid;
      end
      tick();
      lat++;
    end
    bus.i_valid = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_sum"}, 32'(bus.o_sum), 32'(exp_s));
    chk({nm, "_carry"}, 32'(bus.o_carry), 32'(exp_c));
    for (int k = 0; k < hold; k++) begin
      chk({nm, "_hold_valid"}, 32'(bus.o_valid), 32'd1);
      chk({nm, "_hold_sum"}, 32'({bus.o_carry, bus.o_sum}), 32'({exp_c, exp_s}));
      chk({nm, "_hold_ready"}, 32'(bus.o_ready), 32'd0);
      tick();
    end
    bus.i_ready = 1'b1;
    tick();
    chk({nm, "_post_ready"}, 32'(bus.o_ready), 32'd1);
    chk({nm, "_post_valid"}, 32'(bus.o_valid), 32'd0);
    chk({nm, "_post_hold"}, 32'({bus.o_carry, bus.o_sum}), 32'({exp_c, exp_s}));
  endtask

  initial begin
    vec_t       vecs[6];
    logic [8:0] model_q[$];
    logic [8:0] expv;
    int         cyc, last_acc, n_acc, n_res;
    bit         acc, seen_valid;

    vecs[0] = '{8'h12, 8'h34, 8'h46, 1'b0, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 0, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 0, 1'b0};
    vecs[3] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 5, 1'b0};
    vecs[4] = '{8'h0F, 8'h01, 8'h10, 1'b0, 0, 1'b1};
    vecs[5] = '{8'h7F, 8'h81, 8'h00, 1'b1, 2, 1'b0};

    n_cmp = 0; n_err = 0;
    bus.i_a = '0; bus.i_b = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_sum", 32'({bus.o_carry, bus.o_sum}), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry,
            vecs[i].hold, vecs[i].disturb);

    // Abort mid-run: async reset clears everything, no result appears.
    bus.i_a = 8'h80; bus.i_b = 8'h80; bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_before", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.o_valid), 32'd0);
    chk("abort_sum", 32'({bus.o_carry, bus.o_sum}), 32'd0);
    chk("abort_ready", 32'(bus.o_ready), 32'd1);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.o_valid) seen_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);
    chk("abort_ready_after", 32'(bus.o_ready), 32'd1);
    do_op("after_abort", 8'h01, 8'h02, 8'h03, 1'b0, 0, 1'b0);

    // Random back-to-back stream with i_ready tied high.
    bus.i_ready = 1'b1;
    bus.i_a = 8'($urandom); bus.i_b = 8'($urandom); bus.i_valid = 1'b1;
    cyc = 0; last_acc = 0; n_acc = 0; n_res = 0;
    while (n_res < 100 && cyc < 5000) begin
      acc = bus.o_ready && bus.i_valid;
      if (acc) model_q.push_back({1'b0, bus.i_a} + {1'b0, bus.i_b});
      if (bus.o_valid) begin
        expv = (model_q.size() > 0) ? model_q.pop_front() : 9'h1FF;
        chk($sformatf("rand%0d", n_res), 32'({bus.o_carry, bus.o_sum}), 32'(expv));
        n_res++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (n_acc > 0) chk("rand_period", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
        n_acc++;
        if (n_acc < 100) begin
          bus.i_a = 8'($urandom); bus.i_b = 8'($urandom);
        end else begin
          bus.i_valid = 1'b0;
        end
      end
    end
    chk("rand_results", 32'(n_res), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
